// File: rtl/uart_pkg.sv
// Shared UART receiver constants: per-baud tick divisors, baud-select codes and FSM state encoding.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int DIV_W              = 7;

    typedef enum logic [1:0] {
        BAUD_19200  = 2'b00,
        BAUD_38400  = 2'b01,
        BAUD_57600  = 2'b10,
        BAUD_115200 = 2'b11
    } baud_sel_e;

    // clk cycles per 1/16 bit at 32 MHz
    localparam logic [DIV_W-1:0] DIV_19200  = 7'd104;
    localparam logic [DIV_W-1:0] DIV_38400  = 7'd52;
    localparam logic [DIV_W-1:0] DIV_57600  = 7'd35;
    localparam logic [DIV_W-1:0] DIV_115200 = 7'd17;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    function automatic logic [DIV_W-1:0] baud_divisor(input logic [1:0] sel);
        case (baud_sel_e'(sel))
            BAUD_19200:  return DIV_19200;
            BAUD_38400:  return DIV_38400;
            BAUD_57600:  return DIV_57600;
            default:     return DIV_115200;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clk pulse every div_i cycles, restarted by a synchronous clear.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;

    assign tick_o = !clr_i && (cnt_q == div_i - DIV_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) holding one byte
// with valid, framing, overrun and parity flags for the UART register file.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic [1:0] baud_sel,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [3:0] SAMP_MID  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SAMP_HALF = 4'(OVERSAMPLE / 2 - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    rx_state_e              state_q;
    logic [DIV_W-1:0]       div_q;
    logic [3:0]             samp_q;
    logic [2:0]             bit_q;
    logic [7:0]             shift_q;
    logic [7:0]             rx_data_q;
    logic                   rx_valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   tick;
    logic                   at_mid;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q;
    logic                   parity_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // The divider is held cleared in IDLE so the first tick lands a full divisor after detection.
    uart_baud_tick u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == ST_IDLE),
        .div_i  (div_q),
        .tick_o (tick)
    );

    assign at_mid = tick && (samp_q == SAMP_MID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            div_q       <= DIV_115200;
            samp_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // Cleared first so that a flag set later in this cycle wins over rd_ack.
            if (rd_ack) begin
                rx_valid_q  <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end

            if (!rx_en) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state_q <= ST_START;
                            samp_q  <= '0;
                            bit_q   <= '0;
                            div_q   <= baud_divisor(baud_sel);
                        end
                    end
                    ST_START: begin
                        if (tick) begin
                            if (samp_q == SAMP_HALF) begin
                                samp_q  <= '0;
                                state_q <= rx_s ? ST_IDLE : ST_DATA;
                            end else begin
                                samp_q <= samp_q + 4'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (tick) samp_q <= at_mid ? 4'd0 : samp_q + 4'd1;
                        if (at_mid) begin
                            shift_q <= {rx_s, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) state_q <= AFTER_DATA;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (tick) samp_q <= at_mid ? 4'd0 : samp_q + 4'd1;
                        if (at_mid) begin
                            par_bad_q <= rx_s ^ (^shift_q);
                            state_q   <= ST_STOP;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (tick) samp_q <= at_mid ? 4'd0 : samp_q + 4'd1;
                        if (at_mid) begin
                            if (rx_s) begin
                                if (!rx_valid_q || rd_ack) begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
`ifdef UART_RX_PARITY_EN
                                if (par_bad_q) parity_err_q <= 1'b1;
`endif
                                state_q <= ST_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_WAIT_IDLE;
                            end
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (rx_s) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model plus directed hand-checked scenarios.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b0;
    logic [1:0] baud_sel = 2'b11;
    logic       rx = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err, busy;

`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    always #5 clk = ~clk;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .rx_en      (rx_en),
        .baud_sel   (baud_sel),
        .rx         (rx),
        .rd_ack     (rd_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Frame-level model: the outcome of a frame lands on the clk edge its stop bit is sampled.
    logic [7:0] exp_data = '0;
    logic       exp_valid = 1'b0, exp_fe = 1'b0, exp_ov = 1'b0, exp_pe = 1'b0;
    logic       old_valid;
    int         ev_due = -1;
    logic [7:0] ev_data = '0;
    bit         ev_stop_ok = 1'b0, ev_par_bad = 1'b0;
    int         start_cyc = 0, rise_cyc = 0;
    logic       prev_valid = 1'b0;

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'b00:   return 104;
            2'b01:   return 52;
            2'b10:   return 35;
            default: return 17;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_data = '0; exp_valid = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0; exp_pe = 1'b0;
            ev_due = -1;
        end else begin
            cyc++;
            old_valid = exp_valid;
            if (rd_ack) begin
                exp_valid = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0; exp_pe = 1'b0;
            end
            if (ev_due == cyc) begin
                if (ev_stop_ok) begin
                    if (!old_valid || rd_ack) begin
                        exp_data  = ev_data;
                        exp_valid = 1'b1;
                    end else begin
                        exp_ov = 1'b1;
                    end
                    if (ev_par_bad) exp_pe = 1'b1;
                end else begin
                    exp_fe = 1'b1;
                end
                ev_due = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({rx_data, rx_valid, frame_err, overrun, parity_err} !==
                {exp_data, exp_valid, exp_fe, exp_ov, exp_pe}) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL model_cmp cyc=%0d got data=%h v=%b fe=%b ov=%b pe=%b required data=%h v=%b fe=%b ov=%b pe=%b",
                             cyc, rx_data, rx_valid, frame_err, overrun, parity_err,
                             exp_data, exp_valid, exp_fe, exp_ov, exp_pe);
            end
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = rx_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic ack();
        @(negedge clk); rd_ack = 1'b1;
        @(negedge clk); rd_ack = 1'b0;
    endtask

    // Sends one frame. With stop_ok=0 the stop bit is driven low and rx is left low on return.
    task automatic send_frame(input logic [7:0] b, input logic [1:0] sel, input bit stop_ok,
                              input bit ack_done, input bit scramble, input bit bad_par);
        int   div, bt, due;
        logic par;
        div = div_of(sel);
        bt  = 16 * div;
        par = (^b) ^ bad_par;
        @(negedge clk); baud_sel = sel;
        @(negedge clk); rx = 1'b0;
        start_cyc  = cyc;
        ev_data    = b;
        ev_stop_ok = stop_ok;
        ev_par_bad = (PAR != 0) && bad_par;
        due        = cyc + 3 + (8 + 16 * (9 + PAR)) * div;
        ev_due     = due;
        repeat (bt) @(negedge clk);
        if (scramble) baud_sel = ~sel;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bt) @(negedge clk);
        end
        if (PAR != 0) begin
            rx = par;
            repeat (bt) @(negedge clk);
        end
        rx = stop_ok;
        for (int i = 0; i < bt; i++) begin
            if (ack_done) rd_ack = (cyc == due - 1);
            @(negedge clk);
        end
        rd_ack   = 1'b0;
        baud_sel = sel;
        $display("frame byte=%02h sel=%0d stop_ok=%0d ack_done=%0d -> data=%02h v=%b fe=%b ov=%b pe=%b",
                 b, sel, stop_ok, ack_done, rx_data, rx_valid, frame_err, overrun, parity_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", 32'({rx_data, rx_valid, frame_err, overrun, parity_err, busy}), 32'd0);
        rst = 1'b0; rx_en = 1'b1; chk_en = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'hA5, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("basic_latency", 32'(rise_cyc - start_cyc), 32'(2587 + PAR * 272));
        check("basic_data", 32'(rx_data), 32'h0000_00A5);
        check("basic_valid", 32'(rx_valid), 32'd1);

        baud_sel = 2'b01;
        @(negedge clk); rx = 1'b0;
        repeat (3 * 832) @(negedge clk);
        check("busy_midframe", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 check("reset_midframe", 32'({rx_data, rx_valid, frame_err, overrun, parity_err, busy}), 32'd0);
        @(negedge clk); rst = 1'b0; rx = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h3C, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("after_reset_data", 32'(rx_data), 32'h0000_003C);
        check("after_reset_flags", 32'({rx_valid, frame_err, overrun, parity_err}), 32'b1000);
        ack();

        baud_sel = 2'b11;
        @(negedge clk); rx = 1'b0;
        repeat (40) @(negedge clk);
        check("false_start_busy", 32'(busy), 32'd1);
        repeat (45) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check("false_start_idle", 32'(busy), 32'd0);
        check("false_start_flags", 32'({rx_valid, frame_err, overrun, parity_err}), 32'd0);

        send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (272) @(negedge clk);
        check("frame_err_set", 32'(frame_err), 32'd1);
        check("frame_err_novalid", 32'(rx_valid), 32'd0);
        check("frame_err_wait_idle", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("frame_err_released", 32'(busy), 32'd0);
        ack();
        send_frame(8'h12, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("after_ferr_data", 32'(rx_data), 32'h0000_0012);
        check("after_ferr_flags", 32'({rx_valid, frame_err, overrun}), 32'b100);
        ack();

        send_frame(8'h11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("overrun_data", 32'(rx_data), 32'h0000_0011);
        check("overrun_flag", 32'({rx_valid, overrun}), 32'b11);
        ack();
        send_frame(8'h11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("ack_same_cycle_data", 32'(rx_data), 32'h0000_0022);
        check("ack_same_cycle_flags", 32'({rx_valid, overrun}), 32'b10);
        ack();

        @(negedge clk); rx = 1'b0;
        repeat (600) @(negedge clk);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("disable_abort_busy", 32'(busy), 32'd0);
        check("disable_keeps_data", 32'(rx_data), 32'h0000_0022);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rx_en = 1'b1;
        repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("parity_bad_flag", 32'(parity_err), 32'd1);
        check("parity_bad_data", 32'(rx_data), 32'h0000_0007);
        ack();
        send_frame(8'h07, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("parity_good_flag", 32'(parity_err), 32'd0);
        ack();
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
